// File: rtl/arith_seq_unit_pkg.sv
// Shared opcode encodings, FSM state encoding and small helpers for the
// sequential arithmetic core.
package arith_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_CALC   = 2'd1;
    localparam state_t ST_FINISH = 2'd2;

    // Multiply and non-zero divide need WIDTH steps; everything else is single-step.
    function automatic logic is_iterative(input logic [1:0] op, input logic b_zero);
        is_iterative = (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
    endfunction

endpackage

// File: rtl/arith_iter_step.sv
// Combinational single-bit step: one shift-add multiply step or one
// restoring-division step on the shared 2*WIDTH work register.
module arith_iter_step
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]         op,
    input  logic [2*WIDTH-1:0] work,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] work_next
);

    logic [WIDTH:0] mul_sum_s;
    logic [WIDTH:0] div_shift_s;
    logic [WIDTH:0] div_diff_s;

    // Multiply keeps {product high, multiplier} and shifts right; divide keeps
    // {partial remainder, dividend/quotient} and shifts left.
    always_comb begin
        mul_sum_s   = {1'b0, work[2*WIDTH-1:WIDTH]}
                    + (work[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        div_shift_s = work[2*WIDTH-1:WIDTH-1];
        div_diff_s  = div_shift_s - {1'b0, operand};
        work_next   = work;
        case (op)
            OP_MUL: begin
                work_next = {mul_sum_s, work[WIDTH-1:1]};
            end
            OP_DIV: begin
                if (div_shift_s >= {1'b0, operand}) begin
                    work_next = {div_diff_s[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
                end else begin
                    work_next = {div_shift_s[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
                end
            end
            default: begin
                work_next = work;
            end
        endcase
    end

endmodule

// File: rtl/arith_seq_unit.sv
// Multi-cycle add/sub/mul/div core with a start/done handshake and bounded,
// operand-independent latency.
module arith_seq_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t                state_r;
    logic [1:0]            op_r;
    logic [WIDTH-1:0]      a_r;
    logic [WIDTH-1:0]      b_r;
    logic [2*WIDTH-1:0]    work_r;
    logic [CW-1:0]         cnt_r;
    logic                  busy_r;
    logic                  done_r;
    logic [2*WIDTH-1:0]    result_r;
    logic [WIDTH-1:0]      remainder_r;
    logic                  div_zero_r;

    logic                  accept_s;
    logic                  b_zero_s;
    logic                  last_s;
    logic [WIDTH-1:0]      step_operand_s;
    logic [2*WIDTH-1:0]    next_work_s;
    logic [2*WIDTH-1:0]    fin_result_s;
    logic [WIDTH-1:0]      fin_rem_s;
    logic                  fin_dz_s;

    arith_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op        (op_r),
        .work      (work_r),
        .operand   (step_operand_s),
        .work_next (next_work_s)
    );

    // Handshake qualification and step control.
    always_comb begin
        accept_s       = start && (state_r != ST_CALC);
        b_zero_s       = (b_r == {WIDTH{1'b0}});
        last_s         = !is_iterative(op_r, b_zero_s) || (cnt_r == LAST_ITER);
        step_operand_s = (op_r == OP_MUL) ? a_r : b_r;
    end

    // Final values captured on the last CALC edge; mul/div use the last step's output.
    always_comb begin
        fin_result_s = {(2*WIDTH){1'b0}};
        fin_rem_s    = {WIDTH{1'b0}};
        fin_dz_s     = 1'b0;
        case (op_r)
            OP_ADD: begin
                fin_result_s = {{WIDTH{1'b0}}, a_r} + {{WIDTH{1'b0}}, b_r};
            end
            OP_SUB: begin
                fin_result_s = {{WIDTH{1'b0}}, a_r} - {{WIDTH{1'b0}}, b_r};
            end
            OP_MUL: begin
                fin_result_s = next_work_s;
            end
            OP_DIV: begin
                if (b_zero_s) begin
                    fin_result_s = {(2*WIDTH){1'b1}};
                    fin_rem_s    = a_r;
                    fin_dz_s     = 1'b1;
                end else begin
                    fin_result_s = {{WIDTH{1'b0}}, next_work_s[WIDTH-1:0]};
                    fin_rem_s    = next_work_s[2*WIDTH-1:WIDTH];
                end
            end
            default: begin
                fin_result_s = {(2*WIDTH){1'b0}};
            end
        endcase
    end

    // Control FSM, operand latches, shared work register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            op_r        <= 2'b00;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            work_r      <= {(2*WIDTH){1'b0}};
            cnt_r       <= {CW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            result_r    <= {(2*WIDTH){1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            div_zero_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_FINISH: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        op_r    <= op;
                        a_r     <= a;
                        b_r     <= b;
                        work_r  <= {{WIDTH{1'b0}}, (op == OP_MUL) ? b : a};
                        cnt_r   <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_CALC;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (last_s) begin
                        result_r    <= fin_result_s;
                        remainder_r <= fin_rem_s;
                        div_zero_r  <= fin_dz_s;
                        cnt_r       <= {CW{1'b0}};
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= ST_FINISH;
                    end else begin
                        work_r <= next_work_s;
                        cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;
    assign remainder = remainder_r;
    assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_arith_seq_unit.sv
// Directed, table-driven bench for arith_seq_unit at WIDTH=8, plus
// hand-written sequences for start-while-busy and mid-operation reset.
module tb_arith_seq_unit;
    import arith_pkg::*;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic [W-1:0]   remainder;
    logic           div_zero;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [1:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] res;
        logic [W-1:0]   rem;
        logic           dz;
        int             lat;
    } vec_t;

    vec_t vecs[15];

    arith_seq_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; issues one operation and waits for its done pulse.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [2*W-1:0] er,
                          input logic [W-1:0] erem, input logic edz, input int elat);
        int  lat;
        bit  seen;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op = ~o; a = W'($urandom); b = W'($urandom);
        check({tag, " busy_after_start"}, busy, 1);
        check({tag, " done_after_start"}, done, 0);
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check({tag, " latency"}, lat, elat);
        check({tag, " busy_in_done"}, busy, 0);
        check({tag, " result"}, result, er);
        check({tag, " remainder"}, remainder, erem);
        check({tag, " div_zero"}, div_zero, edz);
    endtask

    initial begin
        int cyc;
        bit seen;

        vecs[0]  = '{OP_ADD, 8'd200, 8'd100, 16'h012C, 8'd0,  1'b0, 1};
        vecs[1]  = '{OP_SUB, 8'd5,   8'd9,   16'hFFFC, 8'd0,  1'b0, 1};
        vecs[2]  = '{OP_SUB, 8'd9,   8'd5,   16'h0004, 8'd0,  1'b0, 1};
        vecs[3]  = '{OP_MUL, 8'd255, 8'd255, 16'hFE01, 8'd0,  1'b0, 8};
        vecs[4]  = '{OP_MUL, 8'd0,   8'd173, 16'h0000, 8'd0,  1'b0, 8};
        vecs[5]  = '{OP_DIV, 8'd200, 8'd7,   16'd28,   8'd4,  1'b0, 8};
        vecs[6]  = '{OP_DIV, 8'd3,   8'd7,   16'd0,    8'd3,  1'b0, 8};
        vecs[7]  = '{OP_DIV, 8'd37,  8'd0,   16'hFFFF, 8'd37, 1'b1, 1};
        vecs[8]  = '{OP_ADD, 8'd1,   8'd2,   16'h0003, 8'd0,  1'b0, 1};
        vecs[9]  = '{OP_MUL, 8'd13,  8'd11,  16'h008F, 8'd0,  1'b0, 8};
        vecs[10] = '{OP_DIV, 8'd255, 8'd1,   16'd255,  8'd0,  1'b0, 8};
        vecs[11] = '{OP_ADD, 8'd255, 8'd255, 16'h01FE, 8'd0,  1'b0, 1};
        vecs[12] = '{OP_DIV, 8'd255, 8'd255, 16'd1,    8'd0,  1'b0, 8};
        vecs[13] = '{OP_SUB, 8'd0,   8'd255, 16'hFF01, 8'd0,  1'b0, 1};
        vecs[14] = '{OP_MUL, 8'd200, 8'd3,   16'h0258, 8'd0,  1'b0, 8};

        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        check("reset remainder", remainder, 0);
        check("reset div_zero", div_zero, 0);

        // Back-to-back: each vector is issued in the previous operation's done cycle.
        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].rem, vecs[i].dz, vecs[i].lat);
        end

        // Let the unit go idle, then confirm no stray done.
        @(posedge clk);
        @(negedge clk);
        check("idle busy", busy, 0);
        check("idle done", done, 0);

        // start re-asserted mid-multiply with new operands must be ignored.
        op = OP_MUL; a = 8'd12; b = 8'd10; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        op = OP_ADD; a = 8'd1; b = 8'd1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        start = 1'b0;
        seen = (done === 1'b1);
        while (!seen && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            seen = (done === 1'b1);
        end
        check("busy_start latency", cyc, 8);
        check("busy_start result", result, 16'h0078);
        check("busy_start remainder", remainder, 0);
        @(posedge clk);
        @(negedge clk);
        check("busy_start no_requeue busy", busy, 0);
        check("busy_start no_requeue done", done, 0);

        // Reset at t0+4 of a multiply: abort without a done pulse.
        op = OP_MUL; a = 8'd255; b = 8'd255; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset result", result, 0);
        check("midreset remainder", remainder, 0);
        check("midreset div_zero", div_zero, 0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("midreset quiet%0d done", k), done, 0);
        end
        run_op("post_reset add", OP_ADD, 8'd7, 8'd8, 16'h000F, 8'd0, 1'b0, 1);
        run_op("post_reset div", OP_DIV, 8'd100, 8'd9, 16'd11, 8'd1, 1'b0, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/arith_seq_unit.md
# arith_seq_unit

Parametrised multi-cycle arithmetic core for the ROM-driven calculator datapath. It takes two unsigned operands and an opcode through a start/done handshake and computes add, subtract, multiply or divide. Multiply uses shift-add and divide uses restoring division, one bit per cycle, so neither relies on repeated addition. It replaces the ALU, the per-operation control sequencing and the quotient/remainder registers with a single block whose latency is bounded and independent of the operand values.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state and outputs
- start  input  1  request; sampled only while busy=0
- op  input  2  opcode: 00 add, 01 sub, 10 mul, 11 div
- a  input  WIDTH  operand A (dividend / minuend), unsigned
- b  input  WIDTH  operand B (divisor / subtrahend), unsigned
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: result/remainder/div_zero valid
- result  output  2*WIDTH  sum, difference, product or quotient
- remainder  output  WIDTH  division remainder; 0 for non-div ops
- div_zero  output  1  last operation was a divide by zero

## Operation
- FSM states: IDLE, CALC, FINISH.
- IDLE: if start=1, latch a, b and op, then go to CALC. busy rises on the next edge.
- CALC runs for L cycles, then goes to FINISH. In FINISH, outputs are written, done=1 and busy=0 for exactly one cycle, and the FSM returns to IDLE. start is accepted in FINISH as in IDLE, so back-to-back operations are possible.
- Latency L: add, sub and divide-by-zero take 1; mul and div take WIDTH.
- add: result = a + b, zero-extended to 2*WIDTH.
- sub: result = a − b, sign-extended two's complement over 2*WIDTH. Example: 5−9 gives all-ones upper half with low byte 0xFC.
- mul: shift-add with a 2*WIDTH accumulator. Examine one multiplier bit per cycle, LSB first. result = a*b exactly, with no overflow possible.
- div: restoring division with a WIDTH+1 bit partial remainder. Produce one quotient bit per cycle, MSB first. result = {WIDTH zeros, quotient} and remainder = a mod b. a<b gives quotient 0 and remainder a.
- div with b=0: skip iteration. result = all ones, remainder = a, div_zero=1.
- div_zero clears on the next accepted operation that is not a divide by zero.
- start while busy=1 is ignored. Operand and op changes during CALC have no effect.
- result, remainder and div_zero hold their values from FINISH until the next FINISH.

## Timing
- Reset values: state IDLE, busy=0, done=0, result=0, remainder=0, div_zero=0, all internal registers 0.
- start sampled high at edge t0 (busy=0): busy=1 after t0. Iteration edges are t0+1 … t0+L−1. Outputs are written at edge t0+L; done=1 and busy=0 hold for the cycle after t0+L.
- Minimum issue interval is L+1 edges. A start asserted during the done cycle is accepted at that cycle's closing edge.
- reset asserted mid-CALC: at the next edge, abort, return to the reset values, and raise no done. Reset has priority over start.
- Iteration counter is clog2(WIDTH)+1 bits and never wraps within an operation.

## Structure
- Package arith_pkg holds the opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV) and the FSM state typedef.
- A single shared iteration counter and one 2*WIDTH work register serve both mul and div.
- Optional sub-module: arith_iter_step, a combinational single-bit shift-add / restore step selected by op. The FSM and registers stay in arith_seq_unit.

## Test plan
- WIDTH=8, add 200+100: done at t0+1 edge, result=0x012C, remainder=0.
- sub 5−9: result=0xFFFC. sub 9−5: result=0x0004.
- mul 255*255: busy for 8 cycles, done after t0+8, result=0xFE01. Also mul 0*173 gives 0.
- div 200/7: result=28, remainder=4, div_zero=0. div 3/7: result=0, remainder=3.
- div 37/0: done after t0+1, result=0xFFFF, remainder=37, div_zero=1. A following add clears div_zero.
- Control and reset: start re-asserted mid-mul with new operands is ignored, and the first result is unchanged. A start in the done cycle issues back-to-back. reset at t0+4 of a mul: no done pulse, all outputs 0, next start behaves normally.
